fifo_port_arbiter: RTL
======================

Name: fifo_port_arbiter

Overview:
- Sequences both ports of the 256-entry byte FIFO.
- Write side: round-robin arbiter that shares the FIFO's single write port among NREQ byte producers. Each producer uses a valid/ready handshake.
- Read side: small FSM that issues FIFO read requests and re-times the registered FIFO output into a valid/ready stream for one consumer, e.g. the UART TX path.
- The block never writes when the FIFO is full and never reads when it is empty.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- DW, 8, data width; must match the FIFO byte width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester byte valid.
- REQ_DATA  in  NREQ*DW  requester i data in bits [i*DW +: DW].
- REQ_READY  out  NREQ  one-hot accept; a byte transfers when REQ_VALID[i] & REQ_READY[i].
- GRANT_ID  out  3  index of the requester granted this cycle; 0 when no grant.
- FIFO_DIN  out  DW  to FIFO DIN.
- FIFO_WE  out  1  to FIFO WE.
- FIFO_FF  in  1  from FIFO FF.
- FIFO_RREQ  out  1  to FIFO RREQ.
- FIFO_DO  in  DW  from FIFO DO (registered in the FIFO; valid the cycle after RREQ).
- FIFO_FE  in  1  from FIFO FE.
- OUT_VALID  out  1  output byte valid.
- OUT_DATA  out  DW  output byte.
- OUT_READY  in  1  consumer accept.

Behaviour:
- Reset (RST_N low, asynchronous):
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Read FSM = IDLE; OUT_VALID = 0; OUT_DATA = 0.
  - All combinational outputs are 0 while RST_N is low: REQ_READY, FIFO_WE, FIFO_RREQ, GRANT_ID, FIFO_DIN.
- Write arbitration (combinational grant, registered pointer):
  - Search order: last_grant+1, last_grant+2, ... modulo NREQ. The first requester with REQ_VALID=1 wins.
  - Grant is issued only if FIFO_FF = 0. Then REQ_READY[g] = 1, FIFO_WE = 1, FIFO_DIN = REQ_DATA[g], GRANT_ID = g.
  - At the clock edge of a grant, last_grant <= g. With no grant, last_grant holds.
  - FIFO_FF = 1: no REQ_READY asserted, FIFO_WE = 0, pointer frozen. Requesters hold data; nothing is dropped.
  - At most one write per cycle. Requesters must keep REQ_VALID and REQ_DATA stable until accepted.
- Read FSM, states IDLE, FETCH, HOLD:
  - IDLE: when FIFO_FE = 0, assert FIFO_RREQ for exactly this cycle and go to FETCH. Otherwise stay in IDLE with FIFO_RREQ = 0.
  - FETCH: FIFO_RREQ = 0. FIFO_DO now holds the byte. OUT_DATA <= FIFO_DO, OUT_VALID <= 1, go to HOLD.
  - HOLD: OUT_VALID = 1 and OUT_DATA stable. On OUT_VALID & OUT_READY: OUT_VALID <= 0, go to IDLE.
  - Latency: FIFO non-empty to OUT_VALID = 2 edges. Sustained throughput is 1 byte per 3 cycles with OUT_READY tied high.
  - FIFO_RREQ is asserted only in IDLE with FIFO_FE = 0. A stale read from an empty FIFO must never occur.
- Simultaneous events:
  - A write and a read in the same cycle are independent and both proceed.
  - FIFO_FF/FIFO_FE are sampled combinationally in the same cycle as WE/RREQ.
- Reset mid-operation:
  - Any byte held in OUT_DATA is discarded.
  - An in-flight FETCH is abandoned. The FIFO read pointer has already advanced, so that byte is lost; this is accepted.
- Pointer wrap: last_grant counts modulo NREQ. For non-power-of-2 NREQ, index NREQ-1 wraps to 0.

Optional Feature:
- FIFO_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins and last_grant is not implemented. Starvation of high indices is permitted.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then all four REQ_VALID high with data 0x10, 0x11, 0x12, 0x13 held until accepted, FIFO empty, OUT_READY = 1 -> grants in order 0,1,2,3, one per cycle. FIFO_WE high 4 cycles. OUT_DATA sequence 0x10, 0x11, 0x12, 0x13, each OUT_VALID 2 edges after the FIFO went non-empty.
- Requester 1 and requester 3 continuously valid -> GRANT_ID alternates 1,3,1,3. With FIFO_ARB_FIXED_PRIO_EN defined -> GRANT_ID stays 1.
- Force FIFO_FF = 1 for 5 cycles with REQ_VALID[2] = 1 -> REQ_READY = 0 and FIFO_WE = 0 throughout. On FF release, requester 2 is granted in the first cycle.
- FIFO holds 0xA5, OUT_READY = 0 for 10 cycles -> exactly one FIFO_RREQ pulse, OUT_VALID = 1 with OUT_DATA = 0xA5 held stable. After OUT_READY = 1 -> next RREQ 1 cycle later.
- FIFO_FE = 1 for 20 cycles -> FIFO_RREQ never asserted, OUT_VALID = 0.
- Assert RST_N low asynchronously during HOLD -> OUT_VALID drops immediately without waiting for CLK, FSM returns to IDLE, last_grant = NREQ-1.

Source files
------------

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: drives both ports of a 256-entry byte FIFO.
//
// Write side: NREQ byte producers with valid/ready handshakes share the
// FIFO's single write port. The grant is combinational and the round-robin
// pointer (last_grant) is registered. When FIFO_FF is high, nothing is granted
// and the pointer holds.
// Read side: a three-state FSM (IDLE/FETCH/HOLD) issues one FIFO read, catches
// the registered FIFO output, and presents it as a valid/ready stream.
//
// Configuration macro:
//   FIFO_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid requester
//                            always wins and no round-robin pointer exists.
//                            When undefined (default), the arbiter is round-robin.
//
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   REQ_VALID       per-requester byte valid              [NREQ]
//   REQ_DATA        requester i byte in [i*DW +: DW]      [NREQ*DW]
//   REQ_READY       one-hot accept (combinational)        [NREQ]
//   GRANT_ID        granted requester index, 0 if none    [3]
//   FIFO_DIN/WE     FIFO write data / write enable (combinational)
//   FIFO_FF         FIFO full flag
//   FIFO_RREQ       FIFO read request (combinational)
//   FIFO_DO         FIFO read data, valid the cycle after RREQ
//   FIFO_FE         FIFO empty flag
//   OUT_VALID/DATA  registered output stream
//   OUT_READY       consumer accept

module fifo_port_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    REQ_VALID,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    REQ_READY,
  output logic [2:0]         GRANT_ID,
  output logic [DW-1:0]      FIFO_DIN,
  output logic               FIFO_WE,
  input  logic               FIFO_FF,
  output logic               FIFO_RREQ,
  input  logic [DW-1:0]      FIFO_DO,
  input  logic               FIFO_FE,
  output logic               OUT_VALID,
  output logic [DW-1:0]      OUT_DATA,
  input  logic               OUT_READY
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = 3;

  // Read FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------

  // Unpack the flat requester data bus
  logic [DW-1:0] req_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_a[g] = REQ_DATA[g*DW +: DW];
  end

  logic          gnt_found_c;
  logic [IW-1:0] gnt_idx_c;
  logic          grant_c;

`ifdef FIFO_ARB_FIXED_PRIO_EN

  // Fixed priority: the lowest valid index wins
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found_c && REQ_VALID[IW'(k)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = IW'(k);
      end
    end
  end

`else

  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] last_grant_d;
  logic [IW-1:0] rr_cand_c;

  // Round robin: search from last_grant+1, wrapping modulo NREQ
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    rr_cand_c   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_cand_c = IW'((32'(last_grant_q) + k) % NREQ);
      if (!gnt_found_c && REQ_VALID[rr_cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = rr_cand_c;
      end
    end
  end

  // Pointer moves only on an actual grant
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_c) begin
      last_grant_d = gnt_idx_c;
    end
  end

  // Reset to NREQ-1 so that requester 0 is searched first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= IW'(NREQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

  // A full FIFO or an active reset suppresses every write-side output
  assign grant_c = gnt_found_c & ~FIFO_FF & RST_N;

  // Write-port drive
  always_comb begin
    REQ_READY = '0;
    FIFO_WE   = 1'b0;
    FIFO_DIN  = '0;
    GRANT_ID  = '0;
    if (grant_c) begin
      REQ_READY = NREQ'(1) << gnt_idx_c;
      FIFO_WE   = 1'b1;
      FIFO_DIN  = req_data_a[gnt_idx_c];
      GRANT_ID  = GW'(gnt_idx_c);
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] out_data_d;
  logic          rreq_c;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rreq_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Single-cycle read request, only when data is present
        if (!FIFO_FE) begin
          rreq_c  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The FIFO's registered DO holds the requested byte in this cycle
        out_data_d  = FIFO_DO;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops OUT_VALID without waiting for CLK
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign FIFO_RREQ = rreq_c & RST_N;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

endmodule
